// File: rtl/run_monitor.sv
// run_monitor
//   Run controller placed beside the DLX pipelined CPU. It watches the IF-stage
//   PC, gates CPU execution through run_en and declares completion once the PC
//   reaches PC_LIM. It counts RUN cycles and PC advances. It faults on an
//   exhausted cycle budget (timeout) or on a PC held unchanged for too long
//   (stuck).
//
//   Optional feature: define RUN_MONITOR_BRANCH_CNT_EN to count non-sequential
//   PC changes in branch_count. Without the macro, branch_count is tied to 0.
//
//   Ports:
//     clk           rising-edge system clock
//     reset         synchronous, active-high; overrides everything
//     start         single-cycle pulse; begins a run from IDLE, DONE or FAULT
//     pc_if         CPU fetch PC (currentPC_if)
//     run_en        CPU advance enable, high only in RUN
//     done          high in DONE
//     timeout       sticky cycle-budget fault flag
//     stuck         sticky stuck-PC fault flag
//     state         0 IDLE, 1 RUN, 2 DONE, 3 FAULT
//     cycle_count   cycles spent in RUN this run
//     advance_count RUN cycles where pc_if differed from the previous sample
//     branch_count  non-sequential PC changes (optional feature)

module run_monitor #(
    parameter logic [31:0] PC_LIM      = 32'h00400054,
    parameter int unsigned MAX_CYCLES  = 5000,
    parameter int unsigned STUCK_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pc_if,
    output logic        run_en,
    output logic        done,
    output logic        timeout,
    output logic        stuck,
    output logic [1:0]  state,
    output logic [31:0] cycle_count,
    output logic [31:0] advance_count,
    output logic [31:0] branch_count
);

    localparam logic [31:0] MAX_CYC   = 32'(MAX_CYCLES);
    localparam logic [31:0] STUCK_LIM = 32'(STUCK_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      cur_state;
    state_t      nxt_state;
    logic [31:0] prev_pc;
    logic [31:0] stuck_cnt;
    logic        pc_same;
    logic        clear;
    logic        set_timeout;
    logic        set_stuck;

    assign pc_same = (pc_if == prev_pc);

    // Next-state decode. Termination checks are ordered so that only the
    // highest-priority condition takes effect when several hold together.
    always_comb begin
        nxt_state   = cur_state;
        clear       = 1'b0;
        set_timeout = 1'b0;
        set_stuck   = 1'b0;
        unique case (cur_state)
            IDLE, DONE, FAULT: begin
                if (start) begin
                    nxt_state = RUN;
                    clear     = 1'b1;
                end
            end
            RUN: begin
                if (pc_if >= PC_LIM) begin
                    nxt_state = DONE;
                end else if (cycle_count + 32'd1 == MAX_CYC) begin
                    nxt_state   = FAULT;
                    set_timeout = 1'b1;
                end else if (pc_same && (stuck_cnt + 32'd1 == STUCK_LIM)) begin
                    nxt_state = FAULT;
                    set_stuck = 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // State register, flags and counters. Counters still update on the
    // terminating RUN edge and are frozen afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state     <= IDLE;
            timeout       <= 1'b0;
            stuck         <= 1'b0;
            cycle_count   <= '0;
            advance_count <= '0;
            stuck_cnt     <= '0;
            prev_pc       <= '0;
        end else begin
            cur_state <= nxt_state;
            if (clear) begin
                timeout       <= 1'b0;
                stuck         <= 1'b0;
                cycle_count   <= '0;
                advance_count <= '0;
                stuck_cnt     <= '0;
                prev_pc       <= pc_if;
            end else if (cur_state == RUN) begin
                if (set_timeout) begin
                    timeout <= 1'b1;
                end
                if (set_stuck) begin
                    stuck <= 1'b1;
                end
                cycle_count <= cycle_count + 32'd1;
                if (pc_same) begin
                    stuck_cnt <= stuck_cnt + 32'd1;
                end else begin
                    advance_count <= advance_count + 32'd1;
                    stuck_cnt     <= '0;
                end
                prev_pc <= pc_if;
            end
        end
    end

`ifdef RUN_MONITOR_BRANCH_CNT_EN
    logic [31:0] branch_q;

    // A redirect is any PC change other than the sequential +4 step.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_q <= '0;
        end else if (clear) begin
            branch_q <= '0;
        end else if (cur_state == RUN && !pc_same && (pc_if != prev_pc + 32'd4)) begin
            branch_q <= branch_q + 32'd1;
        end
    end

    assign branch_count = branch_q;
`else
    assign branch_count = '0;
`endif

    assign state  = cur_state;
    assign run_en = (cur_state == RUN);
    assign done   = (cur_state == DONE);

endmodule

// File: tb/tb_run_monitor.sv
// Testbench for run_monitor. Three instances share the stimulus and differ only
// in their budget/stuck parameters. A history-based reference model derives
// every expected output from the list of PCs sampled since the last start.

module tb_run_monitor;

    localparam logic [31:0] LIM  = 32'h00400054;
    localparam logic [31:0] BASE = 32'h00400000;
`ifdef RUN_MONITOR_BRANCH_CNT_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pc_if;

    logic        run_o  [3];
    logic        done_o [3];
    logic        tmo_o  [3];
    logic        stk_o  [3];
    logic [1:0]  st_o   [3];
    logic [31:0] cyc_o  [3];
    logic [31:0] adv_o  [3];
    logic [31:0] br_o   [3];

    always #5 clk = ~clk;

    run_monitor #(.PC_LIM(LIM), .MAX_CYCLES(5000), .STUCK_LIMIT(16)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .pc_if(pc_if),
        .run_en(run_o[0]), .done(done_o[0]), .timeout(tmo_o[0]), .stuck(stk_o[0]),
        .state(st_o[0]), .cycle_count(cyc_o[0]), .advance_count(adv_o[0]),
        .branch_count(br_o[0])
    );

    run_monitor #(.PC_LIM(LIM), .MAX_CYCLES(10), .STUCK_LIMIT(4)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .pc_if(pc_if),
        .run_en(run_o[1]), .done(done_o[1]), .timeout(tmo_o[1]), .stuck(stk_o[1]),
        .state(st_o[1]), .cycle_count(cyc_o[1]), .advance_count(adv_o[1]),
        .branch_count(br_o[1])
    );

    run_monitor #(.PC_LIM(LIM), .MAX_CYCLES(5), .STUCK_LIMIT(4)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .pc_if(pc_if),
        .run_en(run_o[2]), .done(done_o[2]), .timeout(tmo_o[2]), .stuck(stk_o[2]),
        .state(st_o[2]), .cycle_count(cyc_o[2]), .advance_count(adv_o[2]),
        .branch_count(br_o[2])
    );

    // Reference model: hist[0] is the PC loaded at start, hist[k] the k-th RUN
    // sample. Instance i has consumed mlen[i] samples; all counters are
    // recomputed from that prefix.
    int unsigned mmax [3] = '{5000, 10, 5};
    int unsigned mlim [3] = '{16, 4, 4};
    int          ms   [3];
    int unsigned mlen [3];
    bit          mtmo [3];
    bit          mstk [3];
    logic [31:0] hist [$];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] cur_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int unsigned n_adv(input int unsigned n);
        int unsigned c = 0;
        for (int unsigned k = 1; k <= n; k++)
            if (hist[k] != hist[k-1]) c++;
        return c;
    endfunction

    function automatic int unsigned n_br(input int unsigned n);
        int unsigned c = 0;
        for (int unsigned k = 1; k <= n; k++)
            if (hist[k] != hist[k-1] && hist[k] != hist[k-1] + 32'd4) c++;
        return c;
    endfunction

    // Number of consecutive repeated samples ending at sample n.
    function automatic int unsigned n_hold(input int unsigned n);
        int unsigned c = 0;
        int unsigned k = n;
        while (k >= 1 && hist[k] == hist[k-1]) begin
            c++;
            k--;
        end
        return c;
    endfunction

    function automatic bit any_running();
        bit r = 1'b0;
        for (int i = 0; i < 3; i++) if (ms[i] == 1) r = 1'b1;
        return r;
    endfunction

    function automatic bit all_running();
        bit r = 1'b1;
        for (int i = 0; i < 3; i++) if (ms[i] != 1) r = 1'b0;
        return r;
    endfunction

    task automatic model_edge(input bit r, input bit s, input logic [31:0] p);
        if (r) begin
            hist.delete();
            for (int i = 0; i < 3; i++) begin
                ms[i] = 0; mlen[i] = 0; mtmo[i] = 1'b0; mstk[i] = 1'b0;
            end
        end else if (any_running()) begin
            hist.push_back(p);
            for (int i = 0; i < 3; i++) begin
                if (ms[i] == 1) begin
                    mlen[i]++;
                    if (p >= LIM) ms[i] = 2;
                    else if (mlen[i] == mmax[i]) begin ms[i] = 3; mtmo[i] = 1'b1; end
                    else if (n_hold(mlen[i]) == mlim[i]) begin ms[i] = 3; mstk[i] = 1'b1; end
                end
            end
        end else if (s) begin
            hist.delete();
            hist.push_back(p);
            for (int i = 0; i < 3; i++) begin
                ms[i] = 1; mlen[i] = 0; mtmo[i] = 1'b0; mstk[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("i%0d state", i), {30'd0, st_o[i]}, 32'(ms[i]));
            check($sformatf("i%0d run_en", i), {31'd0, run_o[i]}, {31'd0, ms[i] == 1});
            check($sformatf("i%0d done", i), {31'd0, done_o[i]}, {31'd0, ms[i] == 2});
            check($sformatf("i%0d timeout", i), {31'd0, tmo_o[i]}, {31'd0, mtmo[i]});
            check($sformatf("i%0d stuck", i), {31'd0, stk_o[i]}, {31'd0, mstk[i]});
            check($sformatf("i%0d cycle_count", i), cyc_o[i], mlen[i]);
            check($sformatf("i%0d advance_count", i), adv_o[i], n_adv(mlen[i]));
            check($sformatf("i%0d branch_count", i), br_o[i], BR_EN ? n_br(mlen[i]) : 32'd0);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked one falling edge
    // after the rising edge that consumed them.
    task automatic step(input bit r, input bit s, input logic [31:0] p);
        reset = r;
        start = s;
        pc_if = p;
        @(posedge clk);
        model_edge(r, s, p);
        @(negedge clk);
        compare_all();
        reset = 1'b0;
        start = 1'b0;
    endtask

    task automatic finish_run();
        for (int g = 0; g < 200 && any_running(); g++) begin
            cur_pc = cur_pc + 32'd4;
            step(1'b0, 1'b0, cur_pc);
        end
        if (any_running()) check("finish_bound", 32'd1, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned sel;
        int unsigned hold_left;
        bit          r;
        bit          s;

        reset = 1'b1;
        start = 1'b0;
        pc_if = '0;
        for (int i = 0; i < 3; i++) begin
            ms[i] = 0; mlen[i] = 0; mtmo[i] = 1'b0; mstk[i] = 1'b0;
        end
        @(negedge clk);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h12345678);
        step(1'b0, 1'b0, 32'hffff_fff0);

        // Sequential run to the limit; the budget-10/5 instances time out.
        step(1'b0, 1'b1, BASE);
        for (int unsigned k = 0; k < 22; k++) step(1'b0, 1'b0, BASE + 32'(4 * k));
        check("seq cycle_count", cyc_o[0], 32'd22);
        check("seq advance_count", adv_o[0], 32'd21);
        check("seq state", {30'd0, st_o[0]}, 32'd2);
        check("budget10 cycle_count", cyc_o[1], 32'd10);
        check("budget10 timeout", {31'd0, tmo_o[1]}, 32'd1);

        // Limit reached exactly on the last budget cycle is DONE.
        step(1'b0, 1'b1, 32'h00400044);
        for (int unsigned k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h00400044 + 32'(4 * k));
        check("tie state", {30'd0, st_o[2]}, 32'd2);
        check("tie timeout", {31'd0, tmo_o[2]}, 32'd0);

        // Stuck: two advances then a hold at 0x00400008.
        step(1'b0, 1'b1, BASE);
        step(1'b0, 1'b0, BASE + 32'd4);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, BASE + 32'd8);
        check("stuck flag", {31'd0, stk_o[1]}, 32'd1);
        check("stuck cycle_count", cyc_o[1], 32'd6);
        cur_pc = BASE + 32'd8;
        finish_run();

        // Three repeated samples followed by an advance do not fault.
        step(1'b0, 1'b1, BASE);
        step(1'b0, 1'b0, BASE + 32'd4);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, BASE + 32'd8);
        step(1'b0, 1'b0, BASE + 32'd12);
        check("hold3 state", {30'd0, st_o[1]}, 32'd1);
        cur_pc = BASE + 32'd12;
        finish_run();

        // Start ignored in RUN, then reset on the 7th RUN cycle.
        step(1'b0, 1'b1, BASE);
        step(1'b0, 1'b0, BASE);
        step(1'b0, 1'b1, BASE + 32'd4);
        for (int unsigned k = 2; k < 6; k++) step(1'b0, 1'b0, BASE + 32'(4 * k));
        step(1'b1, 1'b0, BASE + 32'd24);
        check("rst state", {30'd0, st_o[0]}, 32'd0);
        check("rst cycle_count", cyc_o[0], 32'd0);

        // Restart from DONE clears the counters.
        step(1'b0, 1'b1, 32'h00400050);
        step(1'b0, 1'b0, LIM);
        step(1'b0, 1'b1, BASE);
        check("restart cycle_count", cyc_o[0], 32'd0);
        cur_pc = BASE;
        finish_run();

        // Redirect counting.
        step(1'b0, 1'b1, BASE);
        step(1'b0, 1'b0, 32'h00400000);
        step(1'b0, 1'b0, 32'h00400004);
        step(1'b0, 1'b0, 32'h00400010);
        step(1'b0, 1'b0, 32'h00400014);
        step(1'b0, 1'b0, 32'h00400004);
        step(1'b0, 1'b0, 32'h00400008);
        check("branch_count", br_o[0], BR_EN ? 32'd2 : 32'd0);
        cur_pc = 32'h00400008;
        finish_run();

        // Randomized runs.
        for (int run = 0; run < 40; run++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, $urandom);
            cur_pc = BASE + 32'(4 * $urandom_range(0, 8));
            hold_left = 0;
            step(1'b0, 1'b1, cur_pc);
            for (int k = 0; k < 150 && any_running(); k++) begin
                if (k >= 120) begin
                    cur_pc = LIM;
                end else if (hold_left > 0) begin
                    hold_left--;
                end else begin
                    sel = $urandom_range(0, 99);
                    if (sel < 65) cur_pc = cur_pc + 32'd4;
                    else if (sel < 82) begin end
                    else if (sel < 85) hold_left = $urandom_range(10, 20);
                    else if (sel < 95) cur_pc = BASE + 32'(4 * $urandom_range(0, 20));
                    else cur_pc = LIM + 32'(4 * $urandom_range(0, 3));
                end
                r = ($urandom_range(0, 199) == 0);
                s = (k == 1) && all_running() && ($urandom_range(0, 1) == 1);
                step(r, s, cur_pc);
            end
            if (any_running()) check("random_bound", 32'd1, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
